// File: rtl/video_mem_arbiter_if.sv
// Signal bundle between the video/CPU requesters, the SRAM pins and video_mem_arbiter.
// The arbiter connects through the slave modport; the surrounding system uses master.
interface video_mem_arbiter_if #(
  parameter int ADDR_W = 17
);
  logic              char_sync;
  logic [11:0]       video_addr;
  logic              video_ram_strobe;
  logic              video_rom_strobe;
  logic [7:0]        video_data;

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [7:0]        cpu_wdata;
  logic [7:0]        cpu_rdata;
  logic              cpu_ack;

  logic [ADDR_W-1:0] sram_addr;
  logic [7:0]        sram_dout;
  logic [7:0]        sram_din;
  logic              sram_oe;
  logic              sram_we;

  modport slave (
    input  char_sync, video_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, sram_din,
    output video_ram_strobe, video_rom_strobe, video_data, cpu_rdata, cpu_ack,
           sram_addr, sram_dout, sram_oe, sram_we
  );

  modport master (
    output char_sync, video_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, sram_din,
    input  video_ram_strobe, video_rom_strobe, video_data, cpu_rdata, cpu_ack,
           sram_addr, sram_dout, sram_oe, sram_we
  );
endinterface

// File: rtl/video_mem_arbiter.sv
// Time-slot SRAM arbiter: slots 0-3 of each 8-pixel character serve video fetches
// (screen RAM then character ROM), slots 4-7 serve at most one CPU access.
module video_mem_arbiter #(
  parameter int                 ADDR_W    = 17,
  parameter logic [ADDR_W-1:0]  VRAM_BASE = 17'h08000,
  parameter logic [ADDR_W-1:0]  CROM_BASE = 17'h10000
) (
  input  logic                clk,
  input  logic                reset,
  video_mem_arbiter_if.slave  bus
);

  logic [2:0] slot;
  logic [2:0] slot_nxt;
  logic       cpu_active;
  logic       cpu_write;

  // Bases have zero low 11 bits, so OR-ing in the offset is an add.
  function automatic logic [ADDR_W-1:0] video_map(input logic [11:0] a);
    return (a[11] ? CROM_BASE : VRAM_BASE) | ADDR_W'(a[10:0]);
  endfunction

  always_comb begin
    slot_nxt = bus.char_sync ? 3'd0 : slot + 3'd1;
  end

  assign bus.video_data = bus.sram_din;

  // Every output is decoded from the slot being entered, so "in slot n" is registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot                 <= 3'd7;
      cpu_active           <= 1'b0;
      cpu_write            <= 1'b0;
      bus.video_ram_strobe <= 1'b0;
      bus.video_rom_strobe <= 1'b0;
      bus.cpu_rdata        <= '0;
      bus.cpu_ack          <= 1'b0;
      bus.sram_addr        <= '0;
      bus.sram_dout        <= '0;
      bus.sram_oe          <= 1'b0;
      bus.sram_we          <= 1'b0;
    end else begin
      slot                 <= slot_nxt;
      bus.video_ram_strobe <= (slot_nxt == 3'd0) || (slot_nxt == 3'd1);
      bus.video_rom_strobe <= (slot_nxt == 3'd2) || (slot_nxt == 3'd3);
      bus.sram_oe          <= 1'b0;
      bus.sram_we          <= 1'b0;
      bus.cpu_ack          <= 1'b0;

      case (slot_nxt)
        3'd1, 3'd3: begin
          bus.sram_addr <= video_map(bus.video_addr);
          bus.sram_oe   <= 1'b1;
          cpu_active    <= 1'b0;
        end
        3'd4: begin
          cpu_active <= bus.cpu_req;
          cpu_write  <= bus.cpu_we;
          if (bus.cpu_req) begin
            bus.sram_addr <= bus.cpu_addr;
            bus.sram_dout <= bus.cpu_wdata;
            bus.sram_oe   <= !bus.cpu_we;
          end
        end
        // Write strobe excludes slot 4 and 7 to give address setup and hold.
        3'd5, 3'd6: begin
          bus.sram_oe <= cpu_active && !cpu_write;
          bus.sram_we <= cpu_active && cpu_write;
        end
        3'd7: begin
          bus.cpu_ack <= cpu_active;
          if (cpu_active && !cpu_write) begin
            bus.cpu_rdata <= bus.sram_din;
          end
          cpu_active <= 1'b0;
        end
        // Entering slot 0 (wrap or char_sync) or slot 2 drops any in-flight access.
        default: begin
          cpu_active <= 1'b0;
        end
      endcase
    end
  end

endmodule
